// File: rtl/seq_divider_16.sv
// seq_divider_16: 16-bit unsigned restoring divider, one quotient bit per cycle.
// Start in IDLE, results and a one-cycle done pulse after the last step.
module seq_divider_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dsr;
    logic             zero;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] q_nx;

    // rem < dsr always holds, so the 17-bit difference cannot overflow
    // and its top bit is a valid sign.
    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        diff    = shifted - {1'b0, dsr};
        qbit    = ~diff[WIDTH];
        rem_nx  = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_nx    = {dvd[WIDTH-2:0], qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd         <= '0;
            rem         <= '0;
            dsr         <= '0;
            zero        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvd         <= dividend;
                        dsr         <= divisor;
                        rem         <= '0;
                        zero        <= (divisor == '0);
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        // a zero divisor takes a single step so done lands after edge N+1
                        cnt         <= (divisor == '0) ? CW'(1) : CW'(WIDTH);
                        state       <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    dvd <= q_nx;
                    rem <= rem_nx;
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        if (zero) begin
                            quotient    <= '1;
                            remainder   <= dvd;
                            div_by_zero <= 1'b1;
                        end else begin
                            quotient  <= q_nx;
                            remainder <= rem_nx;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
